// File: rtl/id_pipe_rf.sv
// Instruction-decode / register-read stage.
// - Internal register file with a hard-wired zero R0.
// - Per-register pending scoreboard that stalls on RAW and WAW hazards.
// - Registered ID/EX bundle behind a valid/ready handshake.
// - Sticky halt that reports only once all in-flight writes have drained.
// Optional feature macro: ID_PIPE_RF_BYPASS_EN. When it is defined, writeback data is
// forwarded to same-cycle operand reads, and a writeback in the current cycle resolves
// its hazard.
module id_pipe_rf #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned IMM_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic              re0,
   input  logic              re1,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic              we_req,
   input  logic [IMM_W-1:0]  imm_in,
   input  logic              hlt_in,
   input  logic              wb_en,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] p0,
   output logic [DATA_W-1:0] p1,
   output logic [ADDR_W-1:0] dst_out,
   output logic              we_out,
   output logic [IMM_W-1:0]  imm_out,
   output logic              hlt
);

   localparam int unsigned NReg = 2 ** ADDR_W;

   logic [DATA_W-1:0] rf_q [NReg];
   logic [NReg-1:0]   pend_q, pend_d, pend_eff, clr_vec, set_vec;
   logic              wb_wr, hazard, accept;
   logic [DATA_W-1:0] rd0, rd1;

   logic              out_valid_q;
   logic [DATA_W-1:0] p0_q, p1_q;
   logic [ADDR_W-1:0] dst_q;
   logic              we_q;
   logic [IMM_W-1:0]  imm_q;
   logic              halted_q, hlt_q;

   assign wb_wr = wb_en && (wb_addr != '0);

   // One-hot writeback clear and accept-time set vectors for the scoreboard.
   always_comb begin
      clr_vec = '0;
      set_vec = '0;
      if (wb_wr) begin
         clr_vec[wb_addr] = 1'b1;
      end
      if (accept && we_req && (dst_addr != '0)) begin
         set_vec[dst_addr] = 1'b1;
      end
   end

`ifdef ID_PIPE_RF_BYPASS_EN
   // A writeback this cycle is forwarded, so it no longer blocks issue.
   assign pend_eff = pend_q & ~clr_vec;
`else
   // Without forwarding the reader must wait until the value lands in the file.
   assign pend_eff = pend_q;
`endif

   // Set wins over clear so a same-cycle retire/re-issue keeps the bit pending.
   assign pend_d = (pend_q & ~clr_vec) | set_vec;

   // RAW on either used source, WAW on the destination.
   always_comb begin
      hazard = 1'b0;
      if (re0 && (p0_addr != '0) && pend_eff[p0_addr]) hazard = 1'b1;
      if (re1 && (p1_addr != '0) && pend_eff[p1_addr]) hazard = 1'b1;
      if (we_req && (dst_addr != '0) && pend_eff[dst_addr]) hazard = 1'b1;
   end

   assign in_ready = !hazard && !halted_q && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;

   // Operand 0 read: unused sources and R0 give zero.
   always_comb begin
      rd0 = '0;
      if (re0 && (p0_addr != '0)) begin
         rd0 = rf_q[p0_addr];
`ifdef ID_PIPE_RF_BYPASS_EN
         if (wb_wr && (wb_addr == p0_addr)) rd0 = wb_data;
`endif
      end
   end

   // Operand 1 read: unused sources and R0 give zero.
   always_comb begin
      rd1 = '0;
      if (re1 && (p1_addr != '0)) begin
         rd1 = rf_q[p1_addr];
`ifdef ID_PIPE_RF_BYPASS_EN
         if (wb_wr && (wb_addr == p1_addr)) rd1 = wb_data;
`endif
      end
   end

   // Register file write port; R0 is never written.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NReg; i++) rf_q[i] <= '0;
      end else if (wb_wr) begin
         rf_q[wb_addr] <= wb_data;
      end
   end

   // Scoreboard pending bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pend_q <= '0;
      else        pend_q <= pend_d;
   end

   // ID/EX bundle: load on accept, drop valid when consumed, otherwise hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         p0_q        <= '0;
         p1_q        <= '0;
         dst_q       <= '0;
         we_q        <= 1'b0;
         imm_q       <= '0;
      end else if (accept) begin
         out_valid_q <= 1'b1;
         p0_q        <= rd0;
         p1_q        <= rd1;
         dst_q       <= dst_addr;
         we_q        <= we_req;
         imm_q       <= imm_in;
      end else if (out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   // Sticky halt latch and drained-halt report.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         halted_q <= 1'b0;
         hlt_q    <= 1'b0;
      end else begin
         if (accept && hlt_in) halted_q <= 1'b1;
         hlt_q <= halted_q && (pend_q == '0) && !out_valid_q;
      end
   end

   assign out_valid = out_valid_q;
   assign p0        = p0_q;
   assign p1        = p1_q;
   assign dst_out   = dst_q;
   assign we_out    = we_q;
   assign imm_out   = imm_q;
   assign hlt       = hlt_q;

endmodule
